ghash_block_sequencer: RTL and testbench

GHASH_BLOCK_SEQUENCER -- requirements
Module: ghash_block_sequencer

---
 rtl/ghash_pkg.sv | 21 ++
 rtl/ghash_byte_mask.sv | 29 ++
 rtl/ghash_block_sequencer.sv | 145 ++++++++++++++
 tb/tb_ghash_block_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghash_pkg.sv
// Shared constants for the GHASH block sequencer: data/length widths, FSM encodings, byte-count normalisation.
package ghash_pkg;

    localparam int GHASH_NB_DATA = 128;
    localparam int GHASH_NB_LEN  = 64;

    typedef logic [2:0] ghash_state_t;

    localparam ghash_state_t ST_IDLE      = 3'd0;
    localparam ghash_state_t ST_ISSUE     = 3'd1;
    localparam ghash_state_t ST_WAIT      = 3'd2;
    localparam ghash_state_t ST_LEN_ISSUE = 3'd3;
    localparam ghash_state_t ST_LEN_WAIT  = 3'd4;
    localparam ghash_state_t ST_DONE      = 3'd5;

    // 0 and anything above 16 mean a full block.
    function automatic logic [4:0] norm_nbytes(input logic [4:0] nbytes);
        return ((nbytes == 5'd0) || (nbytes > 5'd16)) ? 5'd16 : nbytes;
    endfunction

endpackage

// File: rtl/ghash_byte_mask.sv
// Zeroes every byte at index >= nbytes (byte 0 is the MSB byte).
// Latency: combinational. Backpressure: none, pure datapath.
// Reset: none.
module ghash_byte_mask
    import ghash_pkg::*;
#(
    parameter int NB_DATA = GHASH_NB_DATA
) (
    input  logic [NB_DATA-1:0] data,
    input  logic [4:0]         nbytes,
    output logic [NB_DATA-1:0] masked
);

    localparam int NB_BYTES = NB_DATA / 8;

    logic [4:0] nb_eff;

    assign nb_eff = norm_nbytes(nbytes);

    always_comb begin
        masked = '0;
        for (int i = 0; i < NB_BYTES; i++) begin
            if (i < int'(nb_eff)) begin
                masked[NB_DATA-1-8*i -: 8] = data[NB_DATA-1-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/ghash_block_sequencer.sv
// Feeds masked blocks and the running Y to an external GHASH core and emits the tag; GHASH_SEQ_LEN_BLOCK_EN appends {len_a,len_c}.
// Latency: one block per CORE_LATENCY+2 cycles; tag CORE_LATENCY+2 cycles after the last accept (2*CORE_LATENCY+3 with length block).
// Backpressure: o_ready is high only in IDLE; the block never stalls the core.
module ghash_block_sequencer
    import ghash_pkg::*;
#(
    parameter int NB_DATA      = GHASH_NB_DATA,
    parameter int NB_LEN       = GHASH_NB_LEN,
    parameter int CORE_LATENCY = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_sop,
    input  logic               i_last,
    input  logic               i_is_aad,
    input  logic [4:0]         i_nbytes,
    input  logic [NB_DATA-1:0] i_ghash_y,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_data_x,
    output logic [NB_DATA-1:0] o_data_x_prev,
    output logic               o_core_valid,
    output logic [NB_DATA-1:0] o_tag,
    output logic               o_tag_valid
);

    ghash_state_t       state;
    logic [NB_DATA-1:0] y;
    logic [NB_DATA-1:0] x_reg;
    logic [NB_DATA-1:0] tag;
    logic [NB_DATA-1:0] masked;
    logic [3:0]         lat_cnt;
    logic               last_r;
    logic               accept;
    logic               lat_done;

    ghash_byte_mask #(
        .NB_DATA (NB_DATA)
    ) u_mask (
        .data   (i_data),
        .nbytes (i_nbytes),
        .masked (masked)
    );

    assign o_ready       = (state == ST_IDLE) && !i_reset;
    assign accept        = i_valid && o_ready;
    assign lat_done      = (lat_cnt == 4'(CORE_LATENCY - 1));
    assign o_core_valid  = (state == ST_ISSUE) || (state == ST_LEN_ISSUE);
    assign o_tag_valid   = (state == ST_DONE);
    assign o_data_x      = x_reg;
    assign o_data_x_prev = y;
    assign o_tag         = tag;

`ifdef GHASH_SEQ_LEN_BLOCK_EN
    logic [NB_LEN-1:0] len_a;
    logic [NB_LEN-1:0] len_c;
    logic [NB_LEN-1:0] len_inc;

    assign len_inc = NB_LEN'({norm_nbytes(i_nbytes), 3'b000});

    // A new message restarts both counters before this block is counted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            len_a <= '0;
            len_c <= '0;
        end else if (accept) begin
            len_a <= (i_sop ? '0 : len_a) + (i_is_aad ? len_inc : '0);
            len_c <= (i_sop ? '0 : len_c) + (i_is_aad ? '0 : len_inc);
        end
    end
`else
    // Length tracking is compiled out; keep its inputs referenced.
    logic [NB_LEN:0] unused_len_cfg;
    assign unused_len_cfg = {i_is_aad, {NB_LEN{1'b0}}};
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            y       <= '0;
            x_reg   <= '0;
            tag     <= '0;
            lat_cnt <= '0;
            last_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x_reg  <= masked;
                        last_r <= i_last;
                        if (i_sop) begin
                            y <= '0;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_done) begin
                        lat_cnt <= '0;
                        y       <= i_ghash_y;
                        if (last_r) begin
`ifdef GHASH_SEQ_LEN_BLOCK_EN
                            x_reg <= NB_DATA'({len_a, len_c});
                            state <= ST_LEN_ISSUE;
`else
                            tag   <= i_ghash_y;
                            state <= ST_DONE;
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
`ifdef GHASH_SEQ_LEN_BLOCK_EN
                ST_LEN_ISSUE: begin
                    state <= ST_LEN_WAIT;
                end
                ST_LEN_WAIT: begin
                    if (lat_done) begin
                        lat_cnt <= '0;
                        y       <= i_ghash_y;
                        tag     <= i_ghash_y;
                        state   <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_block_sequencer.sv
// Directed bench: models the GHASH core (GF(2^128) multiply by H with CORE_LATENCY delay) and checks tags against
// hand vectors and an independent GHASH model.
module tb_ghash_block_sequencer;

    localparam int L = 2;
    localparam logic [127:0] H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] JUNK = 128'h5a5a5a5a_a5a5a5a5_0badf00d_deadbeef;
`ifdef GHASH_SEQ_LEN_BLOCK_EN
    localparam int LAT = 2 * L + 3;
    localparam int NX  = 1;
`else
    localparam int LAT = L + 2;
    localparam int NX  = 0;
`endif

    logic         i_clock = 1'b0;
    logic         i_reset, i_valid, i_sop, i_last, i_is_aad;
    logic [127:0] i_data, i_ghash_y;
    logic [4:0]   i_nbytes;
    logic         o_ready, o_core_valid, o_tag_valid;
    logic [127:0] o_data_x, o_data_x_prev, o_tag;

    always #5 i_clock = ~i_clock;

    ghash_block_sequencer #(
        .NB_DATA      (128),
        .NB_LEN       (64),
        .CORE_LATENCY (L)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_sop         (i_sop),
        .i_last        (i_last),
        .i_is_aad      (i_is_aad),
        .i_nbytes      (i_nbytes),
        .i_ghash_y     (i_ghash_y),
        .o_ready       (o_ready),
        .o_data_x      (o_data_x),
        .o_data_x_prev (o_data_x_prev),
        .o_core_valid  (o_core_valid),
        .o_tag         (o_tag),
        .o_tag_valid   (o_tag_valid)
    );

    function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] v_in);
        logic [127:0] z, v;
        z = '0;
        v = v_in;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // Core model: result of an issue appears exactly L cycles after the o_core_valid cycle.
    logic [127:0] pipe [L];
    always @(posedge i_clock) begin
        pipe[0] <= o_core_valid ? gf_mult(o_data_x ^ o_data_x_prev, H) : JUNK;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign i_ghash_y = pipe[L-1];

    int           n_assert = 0, n_fail = 0, cyc = 0, issue_cnt = 0, ready_cnt = 0;
    logic [127:0] last_x = '0;
    logic [127:0] tag_q [$];
    int           tag_cyc_q [$];

    always @(negedge i_clock) begin
        if (o_core_valid) begin
            issue_cnt++;
            last_x = o_data_x;
        end
        if (o_tag_valid) begin
            tag_q.push_back(o_tag);
            tag_cyc_q.push_back(cyc);
        end
        if (o_ready) ready_cnt++;
    end

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    // Reference GHASH state, built independently of the DUT.
    logic [127:0] my;
    logic [63:0]  mla, mlc;

    task automatic m_clear();
        my = '0; mla = '0; mlc = '0;
    endtask

    task automatic m_add(input logic [127:0] d, input logic [4:0] nb, input logic aad);
        int n;
        logic [127:0] keep;
        n    = (nb == 5'd0 || nb > 5'd16) ? 16 : int'(nb);
        keep = '1;
        keep = keep << (8 * (16 - n));
        my   = gf_mult(my ^ (d & keep), H);
        if (aad) mla = mla + 64'(8 * n);
        else     mlc = mlc + 64'(8 * n);
    endtask

    function automatic logic [127:0] m_tag();
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        return gf_mult(my ^ {mla, mlc}, H);
`else
        return my;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [127:0] d, input logic [4:0] nb, input logic sop, input logic last,
                        input logic aad, input logic hold, output int acc);
        i_data = d; i_nbytes = nb; i_sop = sop; i_last = last; i_is_aad = aad; i_valid = 1'b1;
        acc = -1;
        for (int w = 0; w < 40 && acc < 0; w++) begin
            if (o_ready) acc = cyc;
            tick();
        end
        if (!hold) i_valid = 1'b0;
        chk_int("send_accepted", int'(acc >= 0), 1);
    endtask

    task automatic sendm(input logic [127:0] d, input logic [4:0] nb, input logic sop, input logic last,
                         input logic aad, input logic hold, output int acc);
        if (sop) m_clear();
        m_add(d, nb, aad);
        send(d, nb, sop, last, aad, hold, acc);
    endtask

    task automatic wait_tag(output logic [127:0] t, output int tc);
        int w;
        w = 0;
        while (tag_q.size() == 0 && w < 60) begin
            tick();
            w++;
        end
        chk_int("tag_arrived", int'(tag_q.size() > 0), 1);
        if (tag_q.size() > 0) begin
            t  = tag_q.pop_front();
            tc = tag_cyc_q.pop_front();
        end else begin
            t  = '0;
            tc = -1;
        end
    endtask

    task automatic expect_msg(input string nm, input logic [127:0] exp, input int acc, input int ic0, input int nblk);
        logic [127:0] t;
        int tc;
        wait_tag(t, tc);
        chk({nm, "_tag"}, t, exp);
        chk_int({nm, "_latency"}, tc - acc, LAT);
        chk_int({nm, "_pulse"}, int'(o_tag_valid), 0);
        chk({nm, "_tag_hold"}, o_tag, exp);
        chk_int({nm, "_issues"}, issue_cnt - ic0, nblk + NX);
        chk_int({nm, "_ready_back"}, int'(o_ready), 1);
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int acc, acc1, ic0, r0;
        logic [127:0] t1, t2, exp1, exp2;
        int tc;

        i_reset = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_last = 1'b0; i_is_aad = 1'b0;
        i_data = '0; i_nbytes = 5'd0;
        m_clear();
        repeat (3) tick();
        chk_int("rst_ready_low", int'(o_ready), 0);
        i_reset = 1'b0;
        #1;
        chk_int("rst_ready_high", int'(o_ready), 1);
        chk("rst_tag", o_tag, '0);
        chk_int("rst_tag_vld", int'(o_tag_valid), 0);
        repeat (6) tick();
        chk_int("rst_no_issue", issue_cnt, 0);

        // Single zero AAD block: Y stays 0; only the length block can make the tag non-zero.
        ic0 = issue_cnt;
        sendm('0, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        chk_int("a_issue_vld", int'(o_core_valid), 1);
        chk("a_issue_x", o_data_x, '0);
        chk_int("a_busy", int'(o_ready), 0);
        expect_msg("a", m_tag(), acc, ic0, 1);
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        chk("a_len_blk", last_x, {64'd128, 64'd0});
`endif

        // NIST GCM test case 2 ciphertext block, hand vectors.
        ic0 = issue_cnt;
        send(128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, acc);
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        expect_msg("b", 128'hf38cbb1ad69223dcc3457ae5b6b0f885, acc, ic0, 1);
`else
        expect_msg("b", 128'h5e2ec746917062882c85b0685353deb7, acc, ic0, 1);
`endif

        // Partial block: only three leading bytes survive.
        tick();
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        chk("c_tag_held", o_tag, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);
`else
        chk("c_tag_held", o_tag, 128'h5e2ec746917062882c85b0685353deb7);
`endif
        ic0 = issue_cnt;
        sendm('1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        chk("c_masked_x", o_data_x, {24'hffffff, 104'd0});
        expect_msg("c", m_tag(), acc, ic0, 1);
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        chk("c_len_blk", last_x, {64'd0, 64'd24});
`endif

        // 2 AAD + 3 C blocks; nbytes 0 and 20 both count as full blocks.
        ic0 = issue_cnt;
        sendm(128'h000102030405060708090a0b0c0d0e0f, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, acc1);
        sendm(128'hfeedfacedeadbeeffeedfacedeadbeef, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk_int("d_throughput", acc - acc1, L + 2);
        sendm(128'h42831ec2217774244b7221b784d0d49c, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        sendm(128'he3aa212f2c02a4e035c17e2329aca12e, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        sendm(128'h21d514b25466931c7d8f6a5aac84aa05, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, acc);
        chk("d_last_masked", o_data_x, {40'h21d514b254, 88'd0});
        expect_msg("d", m_tag(), acc, ic0, 5);
`ifdef GHASH_SEQ_LEN_BLOCK_EN
        chk("d_len_blk", last_x, {64'd256, 64'd296});
`endif

        // Back-to-back messages with i_valid held high throughout.
        tick();
        r0 = ready_cnt;
        sendm(128'h0123456789abcdeffedcba9876543210, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, acc);
        sendm(128'hcafebabe0011223344556677deadc0de, 5'd9,  1'b0, 1'b1, 1'b0, 1'b1, acc);
        exp1 = m_tag();
        sendm(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        exp2 = m_tag();
        chk_int("e_ready_only_idle", ready_cnt - r0, 3);
        wait_tag(t1, tc);
        chk("e_tag1", t1, exp1);
        wait_tag(t2, tc);
        chk("e_tag2_indep", t2, exp2);
        chk_int("e_tag2_latency", tc - acc, LAT);

        // Reset during WAIT: message aborted, late core result ignored.
        repeat (2) tick();
        sendm(128'h00112233445566778899aabbccddeeff, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        chk_int("f_ready_after_rst", int'(o_ready), 1);
        chk("f_tag_cleared", o_tag, '0);
        chk("f_y_cleared", o_data_x_prev, '0);
        repeat (8) tick();
        chk("f_late_ignored", o_data_x_prev, '0);
        chk_int("f_no_tag", tag_q.size(), 0);
        ic0 = issue_cnt;
        m_clear();
        sendm(128'h8899aabbccddeeff0011223344556677, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        expect_msg("f", m_tag(), acc, ic0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
